// File: rtl/move_input_pkg.sv
// Shared types for the 2048 move input conditioner.
// FSM state encoding, direction indices and one-hot direction helpers.
package move_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        FIRE         = 2'd1,
        COOLDOWN     = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;
    localparam int NUM_DIRS  = 4;

    typedef logic [NUM_DIRS-1:0] dir_t;

    // Highest-priority pressed direction as one-hot: up > right > down > left.
    function automatic dir_t pick_dir(input dir_t lv);
        dir_t d;
        d = '0;
        if (lv[DIR_UP])
            d[DIR_UP] = 1'b1;
        else if (lv[DIR_RIGHT])
            d[DIR_RIGHT] = 1'b1;
        else if (lv[DIR_DOWN])
            d[DIR_DOWN] = 1'b1;
        else if (lv[DIR_LEFT])
            d[DIR_LEFT] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/move_input_conditioner_debounce.sv
// Two-flop synchroniser plus stable-level debounce for one push-button.
// The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level once it has disagreed for the full stable window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/move_input_conditioner.sv
// Turns four bouncy buttons into one-hot single-cycle move pulses with cooldown.
// Optional macro AUTOREPEAT_EN adds hold-to-repeat in WAIT_RELEASE.
import move_input_pkg::*;

module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COOLDOWN_CYCLES = 128,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_PERIOD   = 1024,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_up,
    input  logic raw_right,
    input  logic raw_down,
    input  logic raw_left,
    output logic btn_up,
    output logic btn_right,
    output logic btn_down,
    output logic btn_left,
    output logic ready
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    // Every cycle count must fit the shared counter width.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CNT_MAX ||
        COOLDOWN_CYCLES < 0 || COOLDOWN_CYCLES > CNT_MAX ||
        REPEAT_DELAY < 1 || REPEAT_DELAY > CNT_MAX ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > CNT_MAX) begin : g_param_check
        $error("move_input_conditioner: cycle parameter out of range");
    end

    dir_t             level;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    dir_t             last;
    dir_t             last_n;
    dir_t             btn_q;
    logic             ready_q;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic rep_first;
    logic rep_first_n;
    logic rep_off;
    logic rep_off_n;
`endif

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clk(clk), .rst(rst), .raw(raw_up), .level(level[DIR_UP])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clk(clk), .rst(rst), .raw(raw_right), .level(level[DIR_RIGHT])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
        .clk(clk), .rst(rst), .raw(raw_down), .level(level[DIR_DOWN])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clk(clk), .rst(rst), .raw(raw_left), .level(level[DIR_LEFT])
    );

    // State, shared counter and last fired direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= '0;
`ifdef AUTOREPEAT_EN
            rep_first <= 1'b0;
            rep_off   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
`ifdef AUTOREPEAT_EN
            rep_first <= rep_first_n;
            rep_off   <= rep_off_n;
`endif
        end
    end

    // Next state: fire once, cool down, then wait for a full release.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
`ifdef AUTOREPEAT_EN
        rep_first_n = rep_first;
        rep_off_n   = rep_off;
`endif
        unique case (state)
            IDLE: begin
                if (|level) begin
                    state_n = FIRE;
                    last_n  = pick_dir(level);
                    cnt_n   = '0;
`ifdef AUTOREPEAT_EN
                    rep_first_n = 1'b1;
                    rep_off_n   = 1'b0;
`endif
                end
            end
            FIRE: begin
                cnt_n   = '0;
                state_n = (COOLDOWN_CYCLES == 0) ? WAIT_RELEASE : COOLDOWN;
            end
            COOLDOWN: begin
                if (cnt == COOL_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT_RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (level == '0) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
`ifdef AUTOREPEAT_EN
                else if (!rep_off && level == last) begin
                    if (cnt == (rep_first ? DELAY_LAST : PERIOD_LAST)) begin
                        cnt_n       = '0;
                        state_n     = FIRE;
                        rep_first_n = 1'b0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n     = '0;
                    rep_off_n = 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            btn_q   <= (state_n == FIRE) ? last_n : '0;
            ready_q <= (state_n == IDLE);
        end
    end

    assign btn_up    = btn_q[DIR_UP];
    assign btn_right = btn_q[DIR_RIGHT];
    assign btn_down  = btn_q[DIR_DOWN];
    assign btn_left  = btn_q[DIR_LEFT];
    assign ready     = ready_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Randomised and directed bench for move_input_conditioner.
// A timestamp-based reference model predicts btn_* and ready every cycle.
module tb_move_input_conditioner;

    localparam int D  = 4;
    localparam int C  = 8;
    localparam int RD = 16;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] btn;
    logic       ready;
    logic       raw_up, raw_right, raw_down, raw_left;

    assign raw_up    = raw[0];
    assign raw_right = raw[1];
    assign raw_down  = raw[2];
    assign raw_left  = raw[3];

    always #5 clk = ~clk;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_up(raw_up),
        .raw_right(raw_right),
        .raw_down(raw_down),
        .raw_left(raw_left),
        .btn_up(btn[0]),
        .btn_right(btn[1]),
        .btn_down(btn[2]),
        .btn_left(btn[3]),
        .ready(ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: raw delay line, debounced levels, move timing.
    logic [3:0] m_p1, m_p2, m_deb;
    int         m_run [4];
    logic       m_armed;
    logic [3:0] m_btn, m_last;
    int         m_fire, m_edge, m_hold;
    logic       m_dis, m_first;

    function automatic logic [3:0] prio(input logic [3:0] v);
        if (v[0]) return 4'b0001;
        if (v[1]) return 4'b0010;
        if (v[2]) return 4'b0100;
        if (v[3]) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic model_step();
        logic [3:0] s;
        m_edge++;
        if (rst) begin
            m_p1 = 0; m_p2 = 0; m_deb = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_armed = 1; m_btn = 0; m_last = 0;
            m_fire = -1000; m_hold = 0; m_dis = 0; m_first = 0;
            return;
        end
        m_btn = 0;
        if (m_armed) begin
            if (m_deb != 0) begin
                m_btn = prio(m_deb); m_last = m_btn;
                m_armed = 0; m_fire = m_edge;
                m_hold = 0; m_dis = 0; m_first = 1;
            end
        end else if (m_edge >= m_fire + C + 2) begin
            if (m_deb == 0) m_armed = 1;
`ifdef AUTOREPEAT_EN
            else if (!m_dis && m_deb == m_last) begin
                m_hold++;
                if (m_hold == (m_first ? RD : RP)) begin
                    m_btn = m_last; m_fire = m_edge;
                    m_first = 0; m_hold = 0;
                end
            end else begin
                m_hold = 0; m_dis = 1;
            end
`endif
        end
        s = m_p2;
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i] = s[i]; m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1 = raw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; raw = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL reset_hold: btn=%b ready=%b want btn=%b ready=%b",
                         btn, ready, m_btn, m_armed);
            end
        end
        rst = 0;
        tick();
        n_cmp++;
        if (btn !== 4'b0000 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: btn=%b ready=%b want btn=0000 ready=1",
                     btn, ready);
        end
    endtask

    task automatic test_single_press();
        int first_t = -1, pulses = 0, rdy_t = -1;
        raw = 4'b0001;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL single_model t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn != 0) begin
                pulses++;
                if (first_t < 0) first_t = i;
            end
        end
        n_cmp++;
        if (pulses != 1 || first_t != D + 3) begin
            n_bad++;
            $display("FAIL single_timing: pulses=%0d at tick %0d want 1 at tick %0d",
                     pulses, first_t, D + 3);
        end
        raw = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL single_release t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (ready && rdy_t < 0) rdy_t = i;
        end
        n_cmp++;
        if (rdy_t != D + 3) begin
            n_bad++;
            $display("FAIL single_ready: ready at tick %0d want %0d", rdy_t, D + 3);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0, first_t = -1;
        for (int i = 0; i < 12; i++) begin
            raw = ((i / 2) % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL bounce_model i=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn != 0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL bounce_quiet: pulses=%0d want 0", pulses);
        end
        raw = 4'b1000;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL bounce_hold t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn == 4'b1000 && first_t < 0) first_t = i;
        end
        n_cmp++;
        if (first_t != D + 3) begin
            n_bad++;
            $display("FAIL bounce_left: left pulse at tick %0d want %0d", first_t, D + 3);
        end
        raw = 0;
        repeat (30) tick();
    endtask

    task automatic test_priority();
        int p = -1, rights = 0, ups = 0, others = 0;
        raw = 4'b1001;
        for (int i = 1; i <= 80; i++) begin
            if (p > 0 && i == p + 4) raw = 4'b0001;
            if (p > 0 && i == p + 6) raw = 4'b0011;
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL prio_model t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn == 4'b0001) begin
                ups++;
                if (p < 0) p = i;
            end else if (btn == 4'b0010) rights++;
            else if (btn != 0) others++;
        end
        n_cmp++;
        if (ups != 1 || rights != 0 || others != 0) begin
            n_bad++;
            $display("FAIL prio_select: up=%0d right=%0d other=%0d want 1/0/0",
                     ups, rights, others);
        end
        raw = 0;
        repeat (20) tick();
        raw = 4'b0010;
        rights = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL prio_repress t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn == 4'b0010) rights++;
        end
        n_cmp++;
        if (rights != 1) begin
            n_bad++;
            $display("FAIL prio_right: right pulses=%0d want 1", rights);
        end
        raw = 0;
        repeat (30) tick();
    endtask

    task automatic test_reset_cooldown();
        int p = -1, t = -1;
        raw = 4'b0100;
        for (int i = 1; i <= 20 && p < 0; i++) begin
            tick();
            if (btn != 0) p = i;
        end
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                n_cmp++;
                if (btn !== 4'b0000 || ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rstcool_first: btn=%b ready=%b want 0000/1", btn, ready);
                end
            end
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL rstcool_model t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn == 4'b0100 && t < 0) t = i;
        end
        n_cmp++;
        if (t != D + 3) begin
            n_bad++;
            $display("FAIL rstcool_down: down pulse at tick %0d want %0d", t, D + 3);
        end
        raw = 0;
        repeat (30) tick();
    endtask

`ifdef AUTOREPEAT_EN
    task automatic test_autorepeat();
        int times[$];
        int late = 0;
        raw = 4'b0010;
        for (int i = 1; i <= 100; i++) begin
            tick();
            n_cmp++;
            if ({btn, ready} !== {m_btn, m_armed}) begin
                n_bad++;
                $display("FAIL rep_model t=%0d: btn=%b ready=%b want btn=%b ready=%b",
                         i, btn, ready, m_btn, m_armed);
            end
            if (btn == 4'b0010) times.push_back(i);
        end
        n_cmp++;
        if (times.size() != 5 || times[0] != D + 3 || times[1] - times[0] != 1 + C + RD ||
            times[2] - times[1] != 1 + C + RP || times[4] - times[3] != 1 + C + RP) begin
            n_bad++;
            $display("FAIL rep_spacing: %0d pulses, ticks %p want 5 at 7,32,49,66,83",
                     times.size(), times);
        end
        raw = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (btn != 0) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_bad++;
            $display("FAIL rep_stop: pulses after release=%0d want 0", late);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] v;
        int len;
        for (int seg = 0; seg < 150; seg++) begin
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) v = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) v = 0;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            raw = v;
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 299) == 0);
                tick();
                n_cmp++;
                if ({btn, ready} !== {m_btn, m_armed} || (btn & (btn - 4'd1)) != 0) begin
                    n_bad++;
                    $display("FAIL random seg=%0d: btn=%b ready=%b want btn=%b ready=%b",
                             seg, btn, ready, m_btn, m_armed);
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        raw = 0;
        m_edge = 0;
        test_reset();
        test_single_press();
        test_bounce();
        test_priority();
        test_reset_cooldown();
`ifdef AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Upstream stage of the 2048 move engine. Converts four raw, bouncy, asynchronous push-buttons into clean single-cycle one-hot move pulses: btn_up, btn_right, btn_down, btn_left.
- Enforces a cooldown after every move, giving the downstream grid logic time to spawn new tiles before the next move.
- One instance per game, between the board pins and the grid-update block.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a level change on a button.
- COOLDOWN_CYCLES, 128: cycles after a move pulse during which no new move is accepted.
- REPEAT_DELAY, 4096: hold cycles before the first auto-repeat (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 1024: hold cycles between subsequent auto-repeats (AUTOREPEAT_EN only).
- CNT_W, 16: width of every internal counter. All cycle parameters must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- raw_up  in  1  asynchronous raw button, active high
- raw_right  in  1  asynchronous raw button
- raw_down  in  1  asynchronous raw button
- raw_left  in  1  asynchronous raw button
- btn_up  out  1  one-cycle move pulse
- btn_right  out  1  one-cycle move pulse
- btn_down  out  1  one-cycle move pulse
- btn_left  out  1  one-cycle move pulse
- ready  out  1  high while a new press will be accepted (state IDLE)

Behaviour:
- Reset (rst high at a clk edge):
  - Sync flops, debounced levels, counters and btn_* go to 0.
  - ready goes to 1; state goes to IDLE.
  - Reset mid-operation aborts any state. A button still held after reset is re-debounced and fires normally.
- Synchroniser: 2-flop synchroniser per raw input.
- Debounce, per button:
  - When sync ≠ debounced, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES−1 and sync still ≠ debounced, debounced ← sync and the counter clears.
  - When sync == debounced, the counter clears.
- Latency: edge 0 is the first edge sampling a stable raw high. The debounced level rises after edge DEBOUNCE_CYCLES+1. btn_* is high for exactly the cycle after edge DEBOUNCE_CYCLES+2.
- FSM: all outputs are registered.
  - IDLE (ready=1): if any debounced level is high, choose by priority up > right > down > left, drive that btn_* high next cycle, go to FIRE.
  - FIRE: lasts one cycle with exactly one btn_* high; then go to COOLDOWN with the counter at 0.
  - COOLDOWN: count COOLDOWN_CYCLES cycles; then go to WAIT_RELEASE.
  - WAIT_RELEASE: go to IDLE on the first cycle in which all four debounced levels are 0.
- Boundary rules:
  - Simultaneous presses yield a single pulse, chosen by priority.
  - Presses arriving or held during FIRE, COOLDOWN or WAIT_RELEASE never pulse. The user must release all buttons first.
  - A release inside COOLDOWN lets WAIT_RELEASE exit on its first cycle.
  - btn_* outputs are always one-hot or zero.
  - COOLDOWN_CYCLES=0 skips straight to WAIT_RELEASE after FIRE.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- With the macro defined:
  - WAIT_RELEASE counts cycles while the debounced set equals exactly the single direction last fired.
  - When the count reaches REPEAT_DELAY (first repeat) or REPEAT_PERIOD (later repeats), the FSM goes to FIRE with the same direction.
  - Pulse spacing is therefore 1+COOLDOWN_CYCLES+REPEAT_DELAY, then 1+COOLDOWN_CYCLES+REPEAT_PERIOD.
  - Any change in the held set clears the count and disables repeat until a full release.
- Without the macro: no repeat logic is present, and REPEAT_* parameters are ignored.

Decomposition:
- Package move_input_pkg holds:
  - FSM state encoding: IDLE, FIRE, COOLDOWN, WAIT_RELEASE.
  - Direction index constants: DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - A 4-bit one-hot direction typedef.
- Sub-module button_debounce (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES), instantiated four times.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, REPEAT_DELAY=16, REPEAT_PERIOD=8):
- Reset held 3 cycles with raws low -> all btn_*=0, ready=1 on the first cycle after release.
- raw_up rises before edge 0 and is held for 40 cycles -> btn_up=1 only in the cycle after edge 6; no other pulse; ready returns to 1 only after raw_up drops plus the debounce time.
- raw_left toggles every 2 cycles for 12 cycles, then stays high -> no pulse during bouncing; btn_left pulses once, 6 edges after the last toggle.
- raw_up and raw_left rise on the same cycle -> only btn_up pulses. Then release left 3 cycles after the pulse, press right 5 cycles after the pulse and hold it -> no btn_right pulse until all buttons are released and right is pressed again.
- rst asserted during COOLDOWN with raw_down still held -> btn_*=0 and ready=1 on the cycle after reset deasserts; btn_down pulses 6 edges after reset deasserts.
- AUTOREPEAT_EN, raw_right held for 100 cycles -> btn_right pulses at t0, t0+25, t0+42, t0+59 and t0+76 (last pulse only if still held); releasing stops the repeats.
